// File: rtl/configs_loader_dbuf.sv
// Double-buffered config store: words stream into a shadow bank and are copied to the active bank on commit.
// Define CONFIGS_READBACK_EN to add a registered readback port on the shadow bank.
module configs_loader_dbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 26,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             io_start,
    input  logic [DATA_WIDTH-1:0]            io_d_in,
    input  logic                             io_d_valid,
    output logic                             io_d_ready,
    input  logic                             io_commit,
    output logic                             io_busy,
    output logic                             io_done,
    output logic                             io_err_overflow,
    output logic [CNT_WIDTH-1:0]             io_word_count,
`ifdef CONFIGS_READBACK_EN
    input  logic [CNT_WIDTH-1:0]             io_rb_addr,
    output logic [DATA_WIDTH-1:0]            io_rb_data,
`endif
    output logic [DATA_WIDTH*NUM_WORDS-1:0]  io_configs_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                          r_state;
    logic [CNT_WIDTH-1:0]            r_count;
    logic                            r_err;
    logic [DATA_WIDTH-1:0]           r_shadow [NUM_WORDS];
    logic [DATA_WIDTH*NUM_WORDS-1:0] r_active;

    logic w_xfer;
    logic w_commit;
    logic w_last;

    // A start in LOAD drops any same-cycle transfer.
    assign w_xfer   = (r_state == ST_LOAD) && io_d_valid && !io_start;
    assign w_commit = (r_state == ST_FULL) && io_commit;
    assign w_last   = (r_count == CNT_WIDTH'(NUM_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_start) begin
                        r_state <= ST_LOAD;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (io_start) begin
                        r_count <= '0;
                    end else if (io_d_valid) begin
                        r_count <= r_count + CNT_WIDTH'(1);
                        if (w_last) begin
                            r_state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (io_commit) begin
                        r_state <= ST_IDLE;
                        if (io_d_valid) begin
                            r_err <= 1'b1;
                        end
                    end else if (io_start) begin
                        r_state <= ST_LOAD;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end else if (io_d_valid) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_shadow[k] <= '0;
            end
            r_active <= '0;
        end else begin
            if (w_xfer) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (r_count == CNT_WIDTH'(k)) begin
                        r_shadow[k] <= io_d_in;
                    end
                end
            end
            // Whole-bank copy in one edge keeps the fabric from seeing a mixed configuration.
            if (w_commit) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    r_active[k*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[k];
                end
            end
        end
    end

`ifdef CONFIGS_READBACK_EN
    logic [DATA_WIDTH-1:0] r_rb_data;

    // Out-of-range addresses match no entry and read back as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rb_data <= '0;
        end else begin
            r_rb_data <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (io_rb_addr == CNT_WIDTH'(k)) begin
                    r_rb_data <= r_shadow[k];
                end
            end
        end
    end

    assign io_rb_data = r_rb_data;
`endif

    assign io_d_ready      = (r_state == ST_LOAD);
    assign io_busy         = (r_state == ST_LOAD);
    assign io_done         = (r_state == ST_FULL);
    assign io_err_overflow = r_err;
    assign io_word_count   = r_count;
    assign io_configs_out  = r_active;

endmodule

// File: doc/configs_loader_dbuf.md
Name: configs_loader_dbuf

Overview:
- Parametrised, flop-based, double-buffered configuration store; next generation of the per-word config latch bank.
- Config words stream in over a valid/ready handshake and are written by an auto-incrementing pointer into a shadow bank.
- The shadow bank is copied atomically into the active bank on commit, so the fabric never sees a partially loaded configuration.
- Sits between the tile config-load port and the LUT/routing config bits.

Parameters:
- DATA_WIDTH, 32, bits per config word.
- NUM_WORDS, 26, number of config words; active output width is DATA_WIDTH*NUM_WORDS.
- CNT_WIDTH, 6, word-counter width; must satisfy 2^CNT_WIDTH > NUM_WORDS.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_start  in  1  one-cycle pulse: begin a new load at word 0.
- io_d_in  in  DATA_WIDTH  config word.
- io_d_valid  in  1  io_d_in valid.
- io_d_ready  out  1  loader accepts a word this cycle.
- io_commit  in  1  one-cycle pulse: transfer shadow to active.
- io_busy  out  1  high in LOAD.
- io_done  out  1  high in FULL (all NUM_WORDS received, awaiting commit).
- io_err_overflow  out  1  sticky: word offered while FULL.
- io_word_count  out  CNT_WIDTH  words accepted since last start.
- io_configs_out  out  DATA_WIDTH*NUM_WORDS  active bank; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async assert, released synchronously to clk):
  - Shadow and active banks all zero.
  - State IDLE.
  - io_d_ready, io_busy, io_done, io_err_overflow = 0; io_word_count = 0.
  - Reset mid-load discards the partial load; io_configs_out returns to 0 immediately.
- States: IDLE, LOAD, FULL.
- IDLE:
  - io_d_ready = 0; io_d_valid ignored, no error.
  - io_start -> LOAD; count := 0; err cleared.
  - io_commit ignored.
- LOAD:
  - io_d_ready = 1, combinational from state only.
  - Transfer = io_d_valid & io_d_ready: shadow[count] := io_d_in; count := count+1.
  - Transfer at count == NUM_WORDS-1 -> FULL; count ends at NUM_WORDS.
  - io_start in LOAD restarts: count := 0. Any transfer in the same cycle is dropped. Shadow keeps old words until overwritten.
  - io_commit in LOAD ignored; partial loads are never committed.
- FULL:
  - io_done = 1, io_d_ready = 0.
  - io_d_valid = 1 sets io_err_overflow. It stays set until the next io_start or reset; data is discarded.
  - io_commit: at that edge active := shadow, state -> IDLE. io_configs_out shows the new values the cycle after the commit edge, for all words simultaneously.
  - io_start without io_commit in FULL -> LOAD, count := 0; active bank unchanged.
  - io_start and io_commit together in FULL: commit wins, start ignored, state -> IDLE.
- Latency:
  - Word accepted at edge N is in shadow after N; never visible on io_configs_out before a commit.
  - Commit-to-output: 1 edge.
- Active bank changes only on commit or reset.
- io_word_count never exceeds NUM_WORDS and never wraps.

Optional Feature:
- Macro: CONFIGS_READBACK_EN.
- Defined:
  - Adds io_rb_addr (in, CNT_WIDTH) and io_rb_data (out, DATA_WIDTH).
  - io_rb_data is registered and equals shadow[io_rb_addr] one cycle after address presentation.
  - Address >= NUM_WORDS returns 0; reset value 0.
  - Readback never affects load state.
- Undefined: both ports and the read register are absent; all other behaviour identical.

Test Plan:
- Reset, then start and stream 26 words 0x1000+k with valid held high -> ready high for exactly 26 cycles; done=1, count=26; io_configs_out still 0; commit -> next cycle word k = 0x1000+k, state IDLE.
- After the full load, drive valid in FULL with 0xDEADBEEF -> err_overflow=1 and stays set; commit output unchanged by 0xDEADBEEF; next start clears err.
- Load 10 words, pulse start, load 26 words 0xA0+k -> count restarts at 0; after commit every word = 0xA0+k.
- Commit pulsed during LOAD at count=5 -> active bank unchanged; load completes normally.
- Assert reset asynchronously mid-load at count=12 with a committed pattern active -> outputs 0 with no clock edge needed; state IDLE, count 0.
- With CONFIGS_READBACK_EN defined: load 26 words 0x5A00+k, set rb_addr=7 -> rb_data=0x5A07 next cycle; rb_addr=30 -> 0.
